rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arbiter.sv | 133 +++++++++++++
 tb/tb_rr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that is held until a valid/ready handshake.
// Optional build macro RR_ARBITER_LOCK_EN adds lock_i to re-grant the same requester at a handshake.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 16
) (
  input  logic                       clk_i,
  input  logic                       arst_ni,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       gnt_valid_o,
  input  logic                       gnt_ready_i
`ifdef RR_ARBITER_LOCK_EN
  ,
  input  logic                       lock_i
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic               handshake;
  logic               keep_ptr;
  logic [IDX_W-1:0]   search_base;
  logic [IDX_W-1:0]   cand;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;

`ifdef RR_ARBITER_LOCK_EN
  assign keep_ptr = lock_i;
`else
  assign keep_ptr = 1'b0;
`endif

  assign handshake = (state_q == HOLD) && gnt_ready_i;

  // At a handshake the search must already use the post-handshake pointer,
  // so the next grant can be issued on the same edge.
  always_comb begin
    search_base = ptr_q;
    if (handshake) begin
      search_base = keep_ptr ? idx_q : idx_q + 1'b1;
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = search_base + IDX_W'(i);
      if (!sel_found && req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
  end

  // State register
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = HOLD;
          idx_d   = sel_idx;
          gnt_d   = sel_onehot;
        end
      end
      HOLD: begin
        if (handshake) begin
          if (!keep_ptr) begin
            ptr_d = idx_q + 1'b1;
          end
          if (sel_found) begin
            idx_d = sel_idx;
            gnt_d = sel_onehot;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        gnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    gnt_o       = gnt_q;
    gnt_idx_o   = idx_q;
    gnt_valid_o = (state_q == HOLD);
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed table-driven bench for rr_arbiter plus hand sequences for reset, rotation, wrap, hold and fairness.
// Define RR_ARBITER_LOCK_EN for both files to exercise lock_i.
module tb_rr_arbiter;

  localparam int unsigned N  = 16;
  localparam int unsigned IW = $clog2(N);

  logic          clk;
  logic          arst_n;
  logic [N-1:0]  req;
  logic          ready;
  logic          lock;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;

  int n_total;
  int n_pass;

  rr_arbiter #(.NUM_REQ(N)) dut (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .req_i      (req),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid),
    .gnt_ready_i(ready)
`ifdef RR_ARBITER_LOCK_EN
    ,
    .lock_i     (lock)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  req;
    logic          ready;
    logic          valid;
    logic [IW-1:0] idx;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected one-hot bus built from the expected index, independent of the DUT.
  function automatic logic [N-1:0] onehot_of(input logic v, input logic [IW-1:0] i);
    logic [N-1:0] r;
    r = '0;
    if (v) r[i] = 1'b1;
    return r;
  endfunction

  // Downstream priority encoder model: index of the lowest set bit.
  function automatic logic [IW-1:0] enc(input logic [N-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) if (g[i]) r = IW'(i);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [IW-1:0] i);
    check({name, "_valid"}, gnt_valid, v);
    check({name, "_idx"}, gnt_idx, i);
    check({name, "_gnt"}, gnt, onehot_of(v, i));
  endtask

  task automatic apply_reset();
    req   = '0;
    ready = 1'b0;
    lock  = 1'b0;
    @(negedge clk);
    arst_n = 1'b0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  vec_t tbl[13];
  int   wait_cnt[N];

  initial begin
    logic [N-1:0] nreq;
    logic         nready;
    n_total = 0;
    n_pass  = 0;
    arst_n  = 1'b1;
    req     = '0;
    ready   = 1'b0;
    lock    = 1'b0;

    tbl[0]  = '{16'h0000, 1'b1, 1'b0, 4'd0};
    tbl[1]  = '{16'h0020, 1'b0, 1'b1, 4'd5};
    tbl[2]  = '{16'h0020, 1'b0, 1'b1, 4'd5};
    tbl[3]  = '{16'h0020, 1'b1, 1'b1, 4'd5};
    tbl[4]  = '{16'h0000, 1'b1, 1'b0, 4'd0};
    tbl[5]  = '{16'h0041, 1'b0, 1'b1, 4'd6};
    tbl[6]  = '{16'h0041, 1'b1, 1'b1, 4'd0};
    tbl[7]  = '{16'h0041, 1'b1, 1'b1, 4'd6};
    tbl[8]  = '{16'h8000, 1'b1, 1'b1, 4'd15};
    tbl[9]  = '{16'h8001, 1'b1, 1'b1, 4'd0};
    tbl[10] = '{16'h0000, 1'b0, 1'b1, 4'd0};
    tbl[11] = '{16'h0000, 1'b1, 1'b0, 4'd0};
    tbl[12] = '{16'h0003, 1'b1, 1'b1, 4'd1};

    apply_reset();
    check_out("reset", 1'b0, '0);

    for (int k = 0; k < 13; k++) begin
      req   = tbl[k].req;
      ready = tbl[k].ready;
      step();
      check_out($sformatf("vec%0d", k), tbl[k].valid, tbl[k].idx);
    end

    // Asynchronous reset while holding grant 5, then first selection from ptr 0
    apply_reset();
    req = 16'h0020;
    step();
    check_out("pre_rst", 1'b1, 4'd5);
    #2;
    arst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, '0);
    @(posedge clk);
    #1;
    check_out("rst_held", 1'b0, '0);
    arst_n = 1'b1;
    req    = 16'h0020;
    step();
    check_out("post_rst", 1'b1, 4'd5);

    // Rotation with every line requesting and ready tied high
    apply_reset();
    req   = 16'hFFFF;
    ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      check_out($sformatf("rot%0d", k), 1'b1, IW'(k % 16));
    end

    // Wrap: grant 13 sets ptr to 14 at handshake, then 0 and 1 follow
    apply_reset();
    req = 16'h2000;
    step();
    check_out("wrap13", 1'b1, 4'd13);
    req   = 16'h0003;
    ready = 1'b1;
    step();
    check_out("wrap0", 1'b1, 4'd0);
    step();
    check_out("wrap1", 1'b1, 4'd1);

    // Sticky hold: request drops at cycle 3 while ready stays low
    apply_reset();
    req = 16'h0100;
    step();
    for (int k = 0; k < 10; k++) begin
      if (k == 3) req = '0;
      check_out($sformatf("hold%0d", k), 1'b1, 4'd8);
      step();
    end
    ready = 1'b1;
    step();
    check_out("hold_rel", 1'b0, '0);

`ifdef RR_ARBITER_LOCK_EN
    apply_reset();
    req = 16'h0009;
    step();
    check_out("lock_g0", 1'b1, 4'd0);
    ready = 1'b1;
    lock  = 1'b1;
    step();
    check_out("lock_again0", 1'b1, 4'd0);
    lock = 1'b0;
    step();
    check_out("lock_g3", 1'b1, 4'd3);
    lock  = 1'b0;
    ready = 1'b0;
`endif

    // Random stream: lines stay asserted until granted; track handshakes waited
    apply_reset();
    for (int j = 0; j < N; j++) wait_cnt[j] = 0;
    for (int c = 0; c < 400; c++) begin
      check("onehot0", $onehot0(gnt), 1'b1);
      check("valid_or", gnt_valid, |gnt);
      if (gnt_valid) check("enc_idx", gnt_idx, enc(gnt));
      else check("idle_idx", gnt_idx, '0);
      nready = ($urandom_range(0, 2) != 0);
      nreq   = req;
      if (gnt_valid && nready) begin
        for (int j = 0; j < N; j++) begin
          if (req[j]) begin
            if (IW'(j) == gnt_idx) wait_cnt[j] = 0;
            else begin
              wait_cnt[j]++;
              check($sformatf("fair%0d", j), (wait_cnt[j] < N), 1'b1);
            end
          end
        end
        if ($urandom_range(0, 1) != 0) nreq[gnt_idx] = 1'b0;
      end
      for (int j = 0; j < N; j++) begin
        if (!req[j] && $urandom_range(0, 3) == 0) begin
          nreq[j]     = 1'b1;
          wait_cnt[j] = 0;
        end
      end
      req   = nreq;
      ready = nready;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
